// File: rtl/key_debounce_repeat.sv
// Multi-channel key debouncer with registered press/release pulses
// and per-channel auto-repeat.
module key_debounce_repeat #(
    parameter int N_CH       = 5,
    parameter int STABLE_CYC = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int REPEAT_DLY = 24,
    parameter int REPEAT_PER = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] key_raw,
    input  logic [N_CH-1:0] rpt_en,
    output logic [N_CH-1:0] key_level,
    output logic [N_CH-1:0] key_press,
    output logic [N_CH-1:0] key_release,
    output logic [N_CH-1:0] key_repeat
);

    localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY
                                                    : REPEAT_PER;
    localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [CW-1:0] DB_LAST  = CW'(STABLE_CYC - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_t;

    logic [N_CH-1:0] raw_act;
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    logic [CW-1:0] db_cnt_q [N_CH];
    logic [CW-1:0] db_cnt_d [N_CH];

    logic [N_CH-1:0] level_d;
    logic [N_CH-1:0] press_d;
    logic [N_CH-1:0] release_d;
    logic [N_CH-1:0] repeat_d;

    rpt_state_t      st_q [N_CH];
    rpt_state_t      st_d [N_CH];
    logic [RW-1:0]   rc_q [N_CH];
    logic [RW-1:0]   rc_d [N_CH];

    assign raw_act = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_act;
            sync2 <= sync1;
        end
    end

    // Debounce: a run of STABLE_CYC mismatching samples flips the level
    always_comb begin
        level_d   = key_level;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2[i] == key_level[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i]  = '0;
                level_d[i]   = sync2[i];
                press_d[i]   = sync2[i];
                release_d[i] = ~sync2[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CW'(1);
            end
        end
    end

    // Repeat FSM looks at the next level so a release wins over a
    // terminal count landing on the same edge
    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            st_d[i] = st_q[i];
            rc_d[i] = rc_q[i];
            unique case (st_q[i])
                IDLE: begin
                    if (press_d[i] && rpt_en[i]) begin
                        st_d[i] = DELAY;
                        rc_d[i] = '0;
                    end
                end
                DELAY: begin
                    if (!level_d[i] || !rpt_en[i]) begin
                        st_d[i] = IDLE;
                        rc_d[i] = '0;
                    end else if (rc_q[i] == DLY_LAST) begin
                        repeat_d[i] = 1'b1;
                        rc_d[i]     = '0;
                        st_d[i]     = RPT;
                    end else begin
                        rc_d[i] = rc_q[i] + RW'(1);
                    end
                end
                RPT: begin
                    if (!level_d[i] || !rpt_en[i]) begin
                        st_d[i] = IDLE;
                        rc_d[i] = '0;
                    end else if (rc_q[i] == PER_LAST) begin
                        repeat_d[i] = 1'b1;
                        rc_d[i]     = '0;
                    end else begin
                        rc_d[i] = rc_q[i] + RW'(1);
                    end
                end
                default: begin
                    st_d[i] = IDLE;
                    rc_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_repeat  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i] <= '0;
                st_q[i]     <= IDLE;
                rc_q[i]     <= '0;
            end
        end else begin
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_repeat  <= repeat_d;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                st_q[i]     <= st_d[i];
                rc_q[i]     <= rc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Scoreboard bench for key_debounce_repeat: a timing-rule reference
// model queues expected outputs, a negedge monitor compares them.
module tb_key_debounce_repeat;

    localparam int N    = 5;
    localparam int STB  = 8;
    localparam int DLY  = 24;
    localparam int PER  = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_raw;
    logic [N-1:0] rpt_en;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_repeat;

    key_debounce_repeat #(
        .N_CH(N), .STABLE_CYC(STB), .ACTIVE_LOW(1),
        .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .rpt_en(rpt_en),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_repeat(key_repeat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic [N-1:0] rep;
    } exp_t;

    exp_t         expq [$];
    logic [N-1:0] samp [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_press_cnt = 0;
    int d_press_cnt = 0;
    int m_rep_cnt   = 0;
    int d_rep_cnt   = 0;

    // Model: press happens after STB consecutive 2-cycle-late samples
    // disagree with the level; repeats fall at DLY + k*PER after press.
    logic m_lvl [N];
    int   m_run [N];
    bit   m_act [N];
    int   m_tp  [N];

    always @(posedge clk) begin
        exp_t         e;
        logic [N-1:0] synced;
        e = '0;
        cyc++;
        if (!rst_n) begin
            samp.delete();
            for (int i = 0; i < N; i++) begin
                m_lvl[i] = 1'b0;
                m_run[i] = 0;
                m_act[i] = 1'b0;
                m_tp[i]  = 0;
            end
        end else begin
            samp.push_back(~key_raw);
            if (samp.size() > 3) void'(samp.pop_front());
            synced = (samp.size() == 3) ? samp[0] : '0;
            for (int i = 0; i < N; i++) begin
                if (synced[i] != m_lvl[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == STB) begin
                    m_lvl[i] = synced[i];
                    m_run[i] = 0;
                    if (m_lvl[i]) e.prs[i] = 1'b1;
                    else e.rel[i] = 1'b1;
                end
                if (e.prs[i] && rpt_en[i]) begin
                    m_act[i] = 1'b1;
                    m_tp[i]  = cyc;
                end else if (m_act[i]) begin
                    if (!m_lvl[i] || !rpt_en[i]) begin
                        m_act[i] = 1'b0;
                    end else if ((cyc - m_tp[i]) >= DLY &&
                                 ((cyc - m_tp[i] - DLY) % PER) == 0) begin
                        e.rep[i] = 1'b1;
                    end
                end
                e.lvl[i] = m_lvl[i];
            end
        end
        expq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        a = '{lvl: key_level, prs: key_press,
              rel: key_release, rep: key_repeat};
        if (expq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = expq.pop_front();
            if (!rst_n) e = '0;
            m_press_cnt += $countones(e.prs);
            m_rep_cnt   += $countones(e.rep);
            d_press_cnt += $countones(a.prs);
            d_rep_cnt   += $countones(a.rep);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t lvl/prs/rel/rep got %b %b %b %b want %b %b %b %b",
                         $time, a.lvl, a.prs, a.rel, a.rep,
                         e.lvl, e.prs, e.rel, e.rep);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n   = 1'b0;
        key_raw = '1;
        rpt_en  = '0;
        step(3);
        rst_n = 1'b1;
        step(3);

        // single press/release on ch0
        key_raw[0] = 1'b0;
        step(20);
        key_raw[0] = 1'b1;
        step(20);

        // short glitch
        key_raw[0] = 1'b0;
        step(5);
        key_raw[0] = 1'b1;
        step(15);

        // long hold with repeat
        rpt_en[0]  = 1'b1;
        key_raw[0] = 1'b0;
        step(70);
        key_raw[0] = 1'b1;
        step(20);

        // release lands on a due repeat
        key_raw[0] = 1'b0;
        step(DLY + 2 * PER);
        key_raw[0] = 1'b1;
        step(20);

        // simultaneous ch1/ch3, no repeat
        rpt_en     = '0;
        key_raw[1] = 1'b0;
        key_raw[3] = 1'b0;
        step(60);
        key_raw[1] = 1'b1;
        key_raw[3] = 1'b1;
        step(20);

        // enable repeat while already held: no repeats
        key_raw[4] = 1'b0;
        step(20);
        rpt_en[4] = 1'b1;
        step(50);
        key_raw[4] = 1'b1;
        rpt_en[4]  = 1'b0;
        step(20);

        // reset mid-debounce on ch2, held through reset
        rpt_en[2]  = 1'b1;
        key_raw[2] = 1'b0;
        step(7);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(40);
        key_raw[2] = 1'b1;
        step(20);

        // randomized segments
        for (int s = 0; s < 120; s++) begin
            key_raw = N'($urandom);
            if ($urandom_range(0, 3) == 0) rpt_en = N'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                step($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            step($urandom_range(1, 45));
        end

        key_raw = '1;
        step(20);

        checks++;
        if (d_press_cnt != m_press_cnt) begin
            errors++;
            $display("FAIL press_count got %0d want %0d",
                     d_press_cnt, m_press_cnt);
        end
        checks++;
        if (d_rep_cnt != m_rep_cnt) begin
            errors++;
            $display("FAIL repeat_count got %0d want %0d",
                     d_rep_cnt, m_rep_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_repeat.md
KEY_DEBOUNCE_REPEAT -- requirements
Module: key_debounce_repeat

Interface
REQ-001 SHALL have parameter N_CH, default 5: number of independent key channels, 1..16.
REQ-002 SHALL have parameter STABLE_CYC, default 8: consecutive mismatching synced samples needed to change state, at least 1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: when 1, a raw input of 0 means pressed.
REQ-004 SHALL have parameter REPEAT_DLY, default 24: cycles from the press pulse to the first repeat pulse, at least 2.
REQ-005 SHALL have parameter REPEAT_PER, default 6: cycles between later repeat pulses, at least 1.
REQ-006 SHALL have port clk, input, 1 bit: system clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port key_raw, input, N_CH bits: asynchronous raw key inputs.
REQ-009 SHALL have port rpt_en, input, N_CH bits: per-channel auto-repeat enable.
REQ-010 SHALL have port key_level, output, N_CH bits: debounced pressed state, 1 = pressed.
REQ-011 SHALL have port key_press, output, N_CH bits: one-cycle pulse on debounced press.
REQ-012 SHALL have port key_release, output, N_CH bits: one-cycle pulse on debounced release.
REQ-013 SHALL have port key_repeat, output, N_CH bits: one-cycle auto-repeat pulse.

Function
REQ-014 SHALL normalise each key_raw bit to active-high using ACTIVE_LOW, then pass it through a 2-flop synchroniser; sync flops reset to 0 (not pressed).
REQ-015 SHALL keep one debounce counter per channel, ceil(log2(STABLE_CYC)) bits wide with a minimum of 1 bit.
- synced value equals key_level: counter cleared to 0.
- synced value differs and counter < STABLE_CYC-1: counter increments.
- synced value differs and counter == STABLE_CYC-1: key_level takes the synced value and counter clears.
REQ-016 SHALL give a latency of exactly STABLE_CYC+2 rising edges from the first edge that samples a stable new raw value to the change of key_level.
REQ-017 SHALL let any glitch shorter than STABLE_CYC synced cycles leave key_level unchanged, with the counter restarting from 0.
REQ-018 SHALL register key_press and key_release so they assert on the same edge as the key_level 0->1 and 1->0 transitions respectively, for exactly one cycle.
REQ-019 SHALL run a per-channel repeat FSM with states IDLE, DELAY and RPT, plus a shared-width repeat counter sized for max(REPEAT_DLY, REPEAT_PER).
REQ-020 SHALL apply these FSM transitions:
- IDLE -> DELAY on the press edge when rpt_en=1; counter <= 0.
- DELAY: counter increments; when counter == REPEAT_DLY-1, pulse key_repeat, counter <= 0, go to RPT.
- RPT: when counter == REPEAT_PER-1, pulse key_repeat and counter <= 0.
REQ-021 SHALL return the FSM from DELAY or RPT to IDLE, with no repeat pulse, whenever key_level=0 or rpt_en=0 in that cycle; release takes precedence over a terminal count reached on the same edge.
REQ-022 SHALL never assert key_press and key_repeat on the same cycle for a channel; the first repeat comes exactly REPEAT_DLY cycles after key_press.
REQ-023 SHALL NOT start a repeat sequence when rpt_en rises while the key is already held; repeat needs a fresh press.
REQ-024 SHALL keep channels fully independent; simultaneous events on different channels are all reported on the same cycle.

Reset
REQ-025 SHALL, on rst_n=0, immediately clear all sync flops, counters and outputs (key_level, key_press, key_release, key_repeat = 0) and force all FSMs to IDLE.
REQ-026 SHALL, when reset is asserted mid-debounce or mid-repeat, not complete the interrupted change after rst_n deasserts; a key held through reset is re-debounced and yields a fresh key_press.

Verification
REQ-027 Defaults, ch0 raw 1->0 held -> key_level[0]=1 and key_press[0] for 1 cycle, 10 edges after first sampled edge.
REQ-028 Ch0 low pulse of 5 cycles -> no key_level, key_press or key_repeat activity.
REQ-029 rpt_en[0]=1, hold 60 cycles after press -> key_repeat pulses at press+24, +30, +36, +42, ...
REQ-030 Release so key_level falls on the cycle a repeat is due -> key_release pulse, no key_repeat, FSM back in IDLE.
REQ-031 Ch1 and ch3 pressed on the same cycle, rpt_en=0 -> both key_press bits assert together; no key_repeat ever.
REQ-032 rst_n pulsed while ch2 is held at count 5 -> all outputs 0 at once; after release of reset, key_press[2] comes 10 edges later.
